ad9280_scope_sample_packer: RTL and testbench

Reader end of the ADC capture core's sample FIFO interface: consumes one 8-bit sample per valid/ready beat and packs four samples into each 32-bit AXI4-Stream word. Frames are delimited by TLAST and carry a programmable length. Sits between the capture core's data_valid/data_out/data_ready port and the AXI DMA S2MM stream input, in the adc_clk domain.

---
 rtl/ad9280_scope_sample_packer.sv | 148 ++++++++++++++
 tb/tb_ad9280_scope_sample_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad9280_scope_sample_packer.sv
// ad9280_scope_sample_packer: packs 8-bit ADC samples four per 32-bit AXI4-Stream word, framed by TLAST.
// Define SAMPLE_PACKER_HEADER_EN to prefix every frame with a header beat.
module ad9280_scope_sample_packer #(
  parameter int ADC_DATA_WIDTH     = 8,
  parameter int SAMPLE_DEPTH_WIDTH = 16
) (
  input  logic                          adc_clk,
  input  logic                          adc_rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [SAMPLE_DEPTH_WIDTH-1:0] frame_len,
  input  logic                          in_valid,
  input  logic [31:0]                   in_data,
  output logic                          in_ready,
  output logic [31:0]                   m_axis_tdata,
  output logic [3:0]                    m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          len_err,
  output logic                          aborted,
  output logic [7:0]                    frame_seq
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PACK  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef SAMPLE_PACKER_HEADER_EN
  localparam logic [2:0] S_HDR   = 3'd4;
`endif

  logic [2:0]                    state;
  logic [SAMPLE_DEPTH_WIDTH-1:0] len_q, cnt, cnt_nx;
  logic [1:0]                    idx;
  logic [31:0]                   acc, word;
  logic                          take, beat, last_s, room;
  logic                          unused_in_hi;

  function automatic logic [3:0] lanes(input logic [1:0] n);
    return {n == 2'd3, n >= 2'd2, n != 2'd0, 1'b1};
  endfunction

  assign unused_in_hi = ^in_data[31:ADC_DATA_WIDTH];
  assign room     = !m_axis_tvalid || m_axis_tready;
  assign beat     = m_axis_tvalid && m_axis_tready;
  assign in_ready = (state == S_PACK) && !abort && room;
  assign take     = in_valid && in_ready;
  assign cnt_nx   = cnt + 1'b1;
  assign last_s   = cnt_nx == len_q;
  assign word     = acc | (32'(in_data[ADC_DATA_WIDTH-1:0]) << {idx, 3'b000});
  assign busy     = state != S_IDLE;

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state         <= S_IDLE;
      len_q         <= '0;
      cnt           <= '0;
      idx           <= '0;
      acc           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      len_err       <= 1'b0;
      aborted       <= 1'b0;
      frame_seq     <= '0;
    end else begin
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      if (beat) m_axis_tvalid <= 1'b0;
      case (state)
        S_IDLE: if (start && !abort) begin
          if (frame_len == '0) len_err <= 1'b1;
          else begin
            len_q   <= frame_len;
            cnt     <= '0;
            idx     <= '0;
            acc     <= '0;
            aborted <= 1'b0;
`ifdef SAMPLE_PACKER_HEADER_EN
            m_axis_tdata  <= {8'hA5, frame_seq, 16'(frame_len)};
            m_axis_tkeep  <= 4'hF;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            state         <= S_HDR;
`else
            state <= S_PACK;
`endif
          end
        end
`ifdef SAMPLE_PACKER_HEADER_EN
        S_HDR: if (abort) begin
          aborted <= 1'b1;
          if (m_axis_tready) state <= S_IDLE;
          else begin
            m_axis_tlast <= 1'b1;
            state        <= S_DRAIN;
          end
        end else if (m_axis_tready) state <= S_PACK;
`endif
        S_PACK: if (abort) begin
          aborted <= 1'b1;
          // Partial lanes take priority for tlast; otherwise the pending beat closes the frame.
          if (idx != 2'd0) state <= S_FLUSH;
          else if (m_axis_tvalid && !m_axis_tready) begin
            m_axis_tlast <= 1'b1;
            state        <= S_DRAIN;
          end else state <= S_IDLE;
        end else if (take) begin
          cnt <= cnt_nx;
          if (idx == 2'd3 || last_s) begin
            m_axis_tdata  <= word;
            m_axis_tkeep  <= lanes(idx);
            m_axis_tlast  <= last_s;
            m_axis_tvalid <= 1'b1;
            acc           <= '0;
            idx           <= '0;
            if (last_s) state <= S_DRAIN;
          end else begin
            acc <= word;
            idx <= idx + 2'd1;
          end
        end
        S_FLUSH: if (room) begin
          m_axis_tdata  <= acc;
          m_axis_tkeep  <= lanes(idx - 2'd1);
          m_axis_tlast  <= 1'b1;
          m_axis_tvalid <= 1'b1;
          acc           <= '0;
          idx           <= '0;
          state         <= S_DRAIN;
        end
        S_DRAIN: begin
          if (abort) aborted <= 1'b1;
          if (beat && m_axis_tlast) begin
            frame_done <= !(aborted || abort);
            if (!(aborted || abort)) frame_seq <= frame_seq + 8'd1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad9280_scope_sample_packer.sv
// tb_ad9280_scope_sample_packer: scoreboard bench for the ADC sample packer.
module tb_ad9280_scope_sample_packer;
  logic        adc_clk = 0, adc_rst_n = 0, start = 0, abort = 0, in_valid = 0, m_axis_tready = 1;
  logic [15:0] frame_len = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, m_axis_tvalid, m_axis_tlast, busy, frame_done, len_err, aborted;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic [7:0]  frame_seq;

  ad9280_scope_sample_packer dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .start(start), .abort(abort), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .frame_done(frame_done), .len_err(len_err),
    .aborted(aborted), .frame_seq(frame_seq)
  );

  always #5 adc_clk = ~adc_clk;

  int          checks = 0, failures = 0, dones = 0, tr_k = 0;
  logic [7:0]  exp_seq = 0;
  logic [36:0] exp_q[$];
  logic [36:0] held, got, e;
  bit          stall = 0, tr_mode = 0;
  logic [3:0]  tr_pat = 4'b1001;

  always @(posedge adc_clk) if (tr_mode) begin
    #1;
    m_axis_tready = tr_pat[3 - (tr_k % 4)];
    tr_k++;
  end

  always @(negedge adc_clk) begin
    got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (stall) begin
      checks++;
      if (!m_axis_tvalid || got !== held) begin
        failures++;
        $display("FAIL axis_hold got=%0b/%h want=1/%h", m_axis_tvalid, got, held);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got=%h want=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                   got[36:5], got[4:1], got[0], e[36:5], e[4:1], e[0]);
        end
      end
    end
    if (frame_done) dones++;
    stall = m_axis_tvalid && !m_axis_tready;
    held  = got;
  end

  task automatic push_words(input logic [7:0] s[$]);
    logic [31:0] d;
    logic [3:0]  k;
    for (int w = 0; w * 4 < s.size(); w++) begin
      d = 0;
      k = 0;
      for (int b = 0; b < 4 && w * 4 + b < s.size(); b++) begin
        d[b*8 +: 8] = s[w*4+b];
        k[b] = 1'b1;
      end
      exp_q.push_back({d, k, w * 4 + 4 >= s.size()});
    end
  endtask

  task automatic do_start(input logic [15:0] len);
`ifdef SAMPLE_PACKER_HEADER_EN
    exp_q.push_back({8'hA5, exp_seq, len, 4'hF, 1'b0});
`endif
    @(posedge adc_clk); #1;
    start = 1; frame_len = len;
    @(posedge adc_clk); #1;
    start = 0;
  endtask

  task automatic feed(input logic [7:0] s[$], input bit rnd);
    int i = 0, g = 0;
    while (i < s.size() && g < 2000) begin
      @(posedge adc_clk); #1;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = {8'($urandom), 16'($urandom), s[i]};
      @(negedge adc_clk);
      if (in_valid && in_ready) i++;
      g++;
    end
    @(posedge adc_clk); #1;
    in_valid = 0;
    checks++;
    if (i != s.size()) begin
      failures++;
      $display("FAIL feed_timeout got=%0d want=%0d", i, s.size());
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || m_axis_tvalid || exp_q.size() != 0) && g < 500) begin
      @(negedge adc_clk);
      g++;
    end
    repeat (2) @(negedge adc_clk);
    checks++;
    if (g >= 500) begin
      failures++;
      $display("FAIL idle_timeout busy=%0b pending=%0d want busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge adc_clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, busy, in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_axis got=%b%h%h%b%b%b want=0", m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
               m_axis_tlast, busy, in_ready);
    end
    repeat (2) @(posedge adc_clk);
    #1 adc_rst_n = 1;
    @(negedge adc_clk);
    checks++;
    if ({frame_done, len_err, aborted, frame_seq, busy} !== '0) begin
      failures++;
      $display("FAIL reset_status got=%b%b%b%h%b want=0", frame_done, len_err, aborted, frame_seq, busy);
    end
  endtask

  task automatic test_frame(input int n, input logic [7:0] base, input bit rnd, input string nm);
    logic [7:0] s[$];
    int d0 = dones;
    for (int i = 0; i < n; i++) s.push_back(rnd ? 8'($urandom) : base + 8'(i));
    do_start(16'(n));
    push_words(s);
    tr_mode = rnd;
    feed(s, rnd);
    wait_idle();
    tr_mode = 0;
    m_axis_tready = 1;
    exp_seq++;
    checks++;
    if (dones - d0 != 1 || frame_seq !== exp_seq || aborted !== 1'b0) begin
      failures++;
      $display("FAIL %s_status got done=%0d seq=%0d ab=%b want done=1 seq=%0d ab=0",
               nm, dones - d0, frame_seq, aborted, exp_seq);
    end
  endtask

  task automatic test_abort();
    logic [7:0] s[$];
    int d0 = dones;
    for (int i = 0; i < 6; i++) s.push_back(8'h40 + 8'(i));
    do_start(16'd12);
    push_words(s);
    feed(s, 0);
    abort = 1;
    wait_idle();
    abort = 0;
    checks++;
    if (dones != d0 || frame_seq !== exp_seq || aborted !== 1'b1) begin
      failures++;
      $display("FAIL abort_status got done=%0d seq=%0d ab=%b want done=0 seq=%0d ab=1",
               dones - d0, frame_seq, aborted, exp_seq);
    end
  endtask

  task automatic test_len_err_wrap();
    logic [7:0] s[$];
    int d0;
    @(posedge adc_clk); #1;
    start = 1; frame_len = 0;
    @(posedge adc_clk); #1;
    start = 0;
    @(negedge adc_clk);
    checks++;
    if (len_err !== 1'b1 || busy !== 1'b0 || aborted !== 1'b1) begin
      failures++;
      $display("FAIL len_err_pulse got err=%b busy=%b ab=%b want err=1 busy=0 ab=1", len_err, busy, aborted);
    end
    @(negedge adc_clk);
    checks++;
    if (len_err !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL len_err_after got err=%b busy=%b tvalid=%b want 0/0/0", len_err, busy, m_axis_tvalid);
    end
    d0 = dones;
    for (int f = 0; f < 256; f++) begin
      s = {};
      for (int i = 0; i < 4; i++) s.push_back(8'(f + i));
      do_start(16'd4);
      push_words(s);
      feed(s, 0);
      wait_idle();
      exp_seq++;
    end
    checks++;
    if (dones - d0 != 256 || frame_seq !== exp_seq || aborted !== 1'b0) begin
      failures++;
      $display("FAIL seq_wrap got done=%0d seq=%0d ab=%b want done=256 seq=%0d ab=0",
               dones - d0, frame_seq, aborted, exp_seq);
    end
  endtask

  initial begin
    test_reset();
    test_frame(8, 8'h01, 0, "len8");
    test_frame(5, 8'h10, 0, "len5");
    test_frame(16, 8'h00, 1, "rand16");
`ifdef SAMPLE_PACKER_HEADER_EN
    test_frame(4, 8'h60, 0, "hdr4");
`endif
    test_abort();
    test_len_err_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
